// File: rtl/fir_pkg.sv
// Shared FIR constants and the coefficient-loader state and command-byte definitions.
package fir_pkg;

  localparam int SIZE_DEF      = 8;
  localparam int NUM_COEFF_DEF = 4;

  localparam int CMD_W         = 8;
  localparam int CMD_BURST_BIT = 7;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_CMD   = 2'd1,
    LD_DATA  = 2'd2,
    LD_DRAIN = 2'd3
  } ld_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fir_spi_sync.sv
// Brings the slow SPI pins into clk: 2-flop synchronizers plus a third stage for sck/cs_n edges.
module fir_spi_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_sck,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [2:0] sck_sync_q, sck_sync_d;
  logic [2:0] cs_sync_q, cs_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], spi_sck};
    cs_sync_d   = {cs_sync_q[1:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[0], spi_mosi};
  end

  // cs_n idles high so leaving reset with the pin released produces no spurious edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_s   = mosi_sync_q[1];

endmodule

// File: rtl/fir_coeff_loader.sv
// Serial (SPI mode 0) front end that writes coefficient words into coeffs_regs.
// Build option FIR_COEFF_READBACK_EN adds coeffs_in/spi_miso readback of the addressed word.
//
// state | meaning
// IDLE  | no frame; waiting for cs_n to fall with ena high
// CMD   | shifting in the command byte (burst flag, start index)
// DATA  | shifting in coefficient words, one write per word
// DRAIN | frame still open but no more writes accepted
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter  int SIZE      = SIZE_DEF,
  parameter  int NUM_COEFF = NUM_COEFF_DEF,
  localparam int SEL_W     = $clog2(NUM_COEFF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spi_sck,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic [SIZE-1:0]  coeff_data,
  output logic [SEL_W-1:0] coeff_sel,
  output logic             coeff_we,
`ifdef FIR_COEFF_READBACK_EN
  input  logic [NUM_COEFF*SIZE-1:0] coeffs_in,
  output logic             spi_miso,
`endif
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] S_IDLE  = LD_IDLE;
  localparam logic [1:0] S_CMD   = LD_CMD;
  localparam logic [1:0] S_DATA  = LD_DATA;
  localparam logic [1:0] S_DRAIN = LD_DRAIN;

  localparam int SHW   = max_int(SIZE, CMD_W);
  localparam int CNT_W = $clog2(SHW + 1);
  localparam logic [SEL_W:0]   NC_W       = (SEL_W + 1)'(NUM_COEFF);
  localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(NUM_COEFF - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(SIZE - 1);

  logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

  fir_spi_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .mosi_s   (mosi_s)
  );

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SHW-1:0]   shift_q, shift_d, shift_nxt;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             burst_q, burst_d;
  logic             wrote_q, wrote_d;
  logic             err_q, err_d;
  logic [SIZE-1:0]  coeff_data_q, coeff_data_d;
  logic [SEL_W-1:0] coeff_sel_q, coeff_sel_d;
  logic             coeff_we_q, coeff_we_d;
  logic             done_q, done_d;

  assign shift_nxt = {shift_q[SHW-2:0], mosi_s};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    burst_d      = burst_q;
    wrote_d      = wrote_q;
    err_d        = err_q;
    coeff_data_d = coeff_data_q;
    coeff_sel_d  = coeff_sel_q;
    coeff_we_d   = 1'b0;
    done_d       = 1'b0;

    if (!ena) begin
      if (state_q != S_IDLE) err_d = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d   = S_CMD;
            err_d     = 1'b0;
            bit_cnt_d = '0;
            wrote_d   = 1'b0;
            shift_d   = '0;
          end
        end
        S_CMD: begin
          if (cs_rise) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else if (sck_rise) begin
            shift_d = shift_nxt;
            if (bit_cnt_q == CMD_LAST) begin
              bit_cnt_d = '0;
              burst_d   = shift_nxt[CMD_BURST_BIT];
              idx_d     = shift_nxt[SEL_W-1:0];
              if ({1'b0, shift_nxt[SEL_W-1:0]} >= NC_W) begin
                err_d   = 1'b1;
                state_d = S_DRAIN;
              end else begin
                state_d = S_DATA;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (cs_rise) begin
            state_d = S_IDLE;
            if (bit_cnt_q != '0) err_d = 1'b1;
            done_d = wrote_q && !err_q && (bit_cnt_q == '0);
          end else if (sck_rise) begin
            shift_d = shift_nxt;
            if (bit_cnt_q == WORD_LAST) begin
              bit_cnt_d    = '0;
              coeff_data_d = shift_nxt[SIZE-1:0];
              coeff_sel_d  = idx_q;
              coeff_we_d   = 1'b1;
              wrote_d      = 1'b1;
              if (burst_q) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
              else         state_d = S_DRAIN;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          // DRAIN: words are counted only so that an overrun can be flagged
          if (cs_rise) begin
            state_d = S_IDLE;
            done_d  = wrote_q && !err_q;
          end else if (sck_rise) begin
            if (bit_cnt_q == WORD_LAST) begin
              bit_cnt_d = '0;
              err_d     = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      burst_q      <= 1'b0;
      wrote_q      <= 1'b0;
      err_q        <= 1'b0;
      coeff_data_q <= '0;
      coeff_sel_q  <= '0;
      coeff_we_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      burst_q      <= burst_d;
      wrote_q      <= wrote_d;
      err_q        <= err_d;
      coeff_data_q <= coeff_data_d;
      coeff_sel_q  <= coeff_sel_d;
      coeff_we_q   <= coeff_we_d;
      done_q       <= done_d;
    end
  end

  assign coeff_data = coeff_data_q;
  assign coeff_sel  = coeff_sel_q;
  assign coeff_we   = coeff_we_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;

`ifdef FIR_COEFF_READBACK_EN
  logic [SIZE-1:0] tx_q, tx_d;
  logic            load_pend_q, load_pend_d;

  // The load waits for the sck fall after a word starts so the MSB is on the pin before the first rise
  always_comb begin
    tx_d        = tx_q;
    load_pend_d = load_pend_q;
    if (sck_fall) begin
      if (load_pend_q) tx_d = coeffs_in[int'(idx_q)*SIZE +: SIZE];
      else             tx_d = {tx_q[SIZE-2:0], 1'b0};
      load_pend_d = 1'b0;
    end
    if (state_d == S_DATA && (state_q == S_CMD || coeff_we_d)) load_pend_d = 1'b1;
    if (state_d != S_DATA) load_pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q        <= '0;
      load_pend_q <= 1'b0;
    end else begin
      tx_q        <= tx_d;
      load_pend_q <= load_pend_d;
    end
  end

  assign spi_miso = (state_q == S_DATA) & tx_q[SIZE-1];
`else
  logic unused_sck_fall;
  assign unused_sck_fall = sck_fall;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: directed frames plus randomized frames against a frame-level model.
module tb_fir_coeff_loader;

  localparam int SIZE      = 8;
  localparam int NUM_COEFF = 4;
  localparam int SEL_W     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic spi_sck = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic [SIZE-1:0]  coeff_data;
  logic [SEL_W-1:0] coeff_sel;
  logic coeff_we, busy, done, err;
`ifdef FIR_COEFF_READBACK_EN
  logic [NUM_COEFF*SIZE-1:0] coeffs_in = '0;
  logic spi_miso;
  logic [SIZE-1:0] miso_sh = '0;
  always @(posedge spi_sck) miso_sh <= {miso_sh[SIZE-2:0], spi_miso};
`endif

  always #5 clk = ~clk;

  fir_coeff_loader #(.SIZE(SIZE), .NUM_COEFF(NUM_COEFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .spi_sck    (spi_sck),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .coeff_data (coeff_data),
    .coeff_sel  (coeff_sel),
    .coeff_we   (coeff_we),
`ifdef FIR_COEFF_READBACK_EN
    .coeffs_in  (coeffs_in),
    .spi_miso   (spi_miso),
`endif
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [SIZE-1:0]  data;
  } wr_t;

  int  n_cmp = 0;
  int  n_bad = 0;
  wr_t wr_q[$];
  wr_t exp_q[$];
  int  done_cnt = 0;
  int  b2b_cnt = 0;
  int  clk_cnt = 0;
  int  last_rise_clk = 0;
  int  we_clk = 0;
  logic prev_we = 1'b0;
  logic prev_done = 1'b0;
  logic busy_mid = 1'b0;
  logic [7:0] data_buf [0:15];
  logic exp_err, exp_done;

  always @(posedge clk) clk_cnt++;

  always @(negedge clk) begin
    if (coeff_we) begin
      wr_q.push_back({coeff_sel, coeff_data});
      we_clk = clk_cnt;
    end
    if (done) done_cnt++;
    if ((coeff_we && prev_we) || (done && prev_done)) b2b_cnt++;
    prev_we   = coeff_we;
    prev_done = done;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish (got running, required finished)");
    $fatal(1, "watchdog");
  end

  task automatic spi_bit(input logic b);
    spi_mosi = b;
    #50 spi_sck = 1'b1;
    last_rise_clk = clk_cnt;
    #50 spi_sck = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) spi_bit(v[7-i]);
  endtask

  task automatic start_frame();
    wr_q.delete();
    done_cnt = 0;
    b2b_cnt  = 0;
    spi_cs_n = 1'b0;
    #50;
  endtask

  task automatic end_frame();
    #50 spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input int nw, input int partial);
    start_frame();
    spi_bits(cmd, 8);
    repeat (4) @(negedge clk);
    busy_mid = busy;
    for (int w = 0; w < nw; w++) spi_bits(data_buf[w], 8);
    if (partial > 0) spi_bits(data_buf[nw], partial);
    end_frame();
  endtask

  // Frame-level reference: what coeffs_regs should see and how the frame should end
  task automatic model_frame(input logic [7:0] cmd, input int nw, input int partial);
    int idx;
    int written;
    bit burst;
    exp_q.delete();
    idx     = int'(cmd) % (1 << SEL_W);
    burst   = cmd[7];
    written = 0;
    exp_err = 1'b0;
    if (idx >= NUM_COEFF) begin
      exp_err = 1'b1;
    end else begin
      for (int w = 0; w < nw; w++) begin
        if (burst || written == 0) begin
          exp_q.push_back({SEL_W'(idx), data_buf[w]});
          written++;
          idx = (idx + 1) % NUM_COEFF;
        end else begin
          exp_err = 1'b1;
        end
      end
      if (partial > 0 && (burst || written == 0)) exp_err = 1'b1;
    end
    exp_done = (written > 0) && !exp_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({coeff_data, coeff_sel, coeff_we, busy, done, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got data=%h sel=%0d we=%b busy=%b done=%b err=%b, required all 0",
               coeff_data, coeff_sel, coeff_we, busy, done, err);
    end
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({coeff_we, busy, done, err} !== 4'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got we=%b busy=%b done=%b err=%b, required 0",
               coeff_we, busy, done, err);
    end
  endtask

  task automatic test_single_write();
    data_buf[0] = 8'hA5;
    send_frame(8'h02, 1, 0);
    n_cmp++;
    if (busy_mid !== 1'b1) begin n_bad++; $display("FAIL single_busy_mid: got %b, required 1", busy_mid); end
    n_cmp++;
    if (wr_q.size() != 1) begin
      n_bad++; $display("FAIL single_count: got %0d writes, required 1", wr_q.size());
    end else begin
      n_cmp++;
      if (wr_q[0] !== {2'd2, 8'hA5}) begin
        n_bad++; $display("FAIL single_write: got sel=%0d data=%h, required sel=2 data=a5", wr_q[0].sel, wr_q[0].data);
      end
    end
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL single_done: got %0d pulses, required 1", done_cnt); end
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_flags: got err=%b busy=%b, required 0 0", err, busy);
    end
    n_cmp++;
    if (we_clk - last_rise_clk < 3 || we_clk - last_rise_clk > 5) begin
      n_bad++; $display("FAIL single_latency: got %0d clk, required 3..5", we_clk - last_rise_clk);
    end
    n_cmp++;
    if (coeff_data !== 8'hA5 || coeff_sel !== 2'd2) begin
      n_bad++; $display("FAIL single_hold: got sel=%0d data=%h, required 2 a5", coeff_sel, coeff_data);
    end
  endtask

  task automatic test_burst_wrap();
    data_buf[0] = 8'h11; data_buf[1] = 8'h22; data_buf[2] = 8'h33;
    model_frame(8'h83, 3, 0);
    send_frame(8'h83, 3, 0);
    n_cmp++;
    if (wr_q.size() != 3) begin
      n_bad++; $display("FAIL burst_count: got %0d writes, required 3", wr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (wr_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL burst_write[%0d]: got sel=%0d data=%h, required sel=%0d data=%h",
                            i, wr_q[i].sel, wr_q[i].data, exp_q[i].sel, exp_q[i].data);
        end
      end
    end
    n_cmp++;
    if (done_cnt != 1 || err !== 1'b0 || b2b_cnt != 0) begin
      n_bad++; $display("FAIL burst_flags: got done=%0d err=%b b2b=%0d, required 1 0 0", done_cnt, err, b2b_cnt);
    end
  endtask

  task automatic test_partial_word();
    data_buf[0] = 8'hFF;
    send_frame(8'h01, 0, 5);
    n_cmp++;
    if (wr_q.size() != 0 || err !== 1'b1 || done_cnt != 0) begin
      n_bad++; $display("FAIL partial: got writes=%0d err=%b done=%0d, required 0 1 0", wr_q.size(), err, done_cnt);
    end
    start_frame();
    repeat (6) @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL partial_err_clear: got %b, required 0", err); end
    spi_bits(8'h01, 8);
    spi_bits(8'h5A, 8);
    end_frame();
    n_cmp++;
    if (wr_q.size() != 1 || done_cnt != 1 || err !== 1'b0) begin
      n_bad++; $display("FAIL partial_recover: got writes=%0d done=%0d err=%b, required 1 1 0", wr_q.size(), done_cnt, err);
    end else begin
      n_cmp++;
      if (wr_q[0] !== {2'd1, 8'h5A}) begin
        n_bad++; $display("FAIL partial_recover_write: got sel=%0d data=%h, required 1 5a", wr_q[0].sel, wr_q[0].data);
      end
    end
  endtask

  task automatic test_single_overrun();
    data_buf[0] = 8'h7F; data_buf[1] = 8'h55;
    send_frame(8'h00, 2, 0);
    n_cmp++;
    if (wr_q.size() != 1) begin
      n_bad++; $display("FAIL overrun_count: got %0d writes, required 1", wr_q.size());
    end else begin
      n_cmp++;
      if (wr_q[0] !== {2'd0, 8'h7F}) begin
        n_bad++; $display("FAIL overrun_write: got sel=%0d data=%h, required 0 7f", wr_q[0].sel, wr_q[0].data);
      end
    end
    n_cmp++;
    if (err !== 1'b1 || done_cnt != 0) begin
      n_bad++; $display("FAIL overrun_flags: got err=%b done=%0d, required 1 0", err, done_cnt);
    end
  endtask

  task automatic test_reset_abort();
    start_frame();
    spi_bits(8'h02, 8);
    spi_bits(8'hC3, 4);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({coeff_data, coeff_sel, coeff_we, busy, done, err} !== '0) begin
      n_bad++; $display("FAIL reset_async: got data=%h sel=%0d we=%b busy=%b done=%b err=%b, required all 0",
                        coeff_data, coeff_sel, coeff_we, busy, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    spi_bits(8'h30, 4);
    end_frame();
    n_cmp++;
    if (wr_q.size() != 0 || done_cnt != 0) begin
      n_bad++; $display("FAIL reset_no_write: got writes=%0d done=%0d, required 0 0", wr_q.size(), done_cnt);
    end
  endtask

  task automatic test_ena_abort();
    start_frame();
    spi_bits(8'h80, 8);
    spi_bits(8'hE0, 3);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      n_bad++; $display("FAIL ena_abort: got busy=%b err=%b, required 0 1", busy, err);
    end
    ena = 1'b1;
    spi_bits(8'h00, 5);
    end_frame();
    n_cmp++;
    if (wr_q.size() != 0 || done_cnt != 0) begin
      n_bad++; $display("FAIL ena_no_write: got writes=%0d done=%0d, required 0 0", wr_q.size(), done_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    int nw, partial;
    for (int f = 0; f < 20; f++) begin
      cmd     = 8'($urandom);
      nw      = $urandom_range(0, 5);
      partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int w = 0; w < 6; w++) data_buf[w] = 8'($urandom);
      model_frame(cmd, nw, partial);
      send_frame(cmd, nw, partial);
      n_cmp++;
      if (wr_q.size() != exp_q.size()) begin
        n_bad++; $display("FAIL rand_count[%0d]: got %0d writes, required %0d (cmd=%h nw=%0d partial=%0d)",
                          f, wr_q.size(), exp_q.size(), cmd, nw, partial);
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_cmp++;
          if (wr_q[i] !== exp_q[i]) begin
            n_bad++; $display("FAIL rand_write[%0d][%0d]: got sel=%0d data=%h, required sel=%0d data=%h",
                              f, i, wr_q[i].sel, wr_q[i].data, exp_q[i].sel, exp_q[i].data);
          end
        end
      end
      n_cmp++;
      if (err !== exp_err || done_cnt != int'(exp_done) || b2b_cnt != 0) begin
        n_bad++; $display("FAIL rand_flags[%0d]: got err=%b done=%0d b2b=%0d, required err=%b done=%0d b2b=0",
                          f, err, done_cnt, b2b_cnt, exp_err, exp_done);
      end
    end
  endtask

`ifdef FIR_COEFF_READBACK_EN
  task automatic test_readback();
    coeffs_in = {8'hD1, 8'hC2, 8'h3C, 8'hE4};
    data_buf[0] = 8'h99;
    send_frame(8'h01, 1, 0);
    n_cmp++;
    if (miso_sh !== 8'h3C) begin n_bad++; $display("FAIL readback_miso: got %h, required 3c", miso_sh); end
    n_cmp++;
    if (wr_q.size() != 1 || wr_q[0] !== {2'd1, 8'h99}) begin
      n_bad++; $display("FAIL readback_write: got writes=%0d, required one write sel=1 data=99", wr_q.size());
    end
    n_cmp++;
    if (spi_miso !== 1'b0) begin n_bad++; $display("FAIL readback_idle_miso: got %b, required 0", spi_miso); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_partial_word();
    test_single_overrun();
    test_reset_abort();
    test_ena_abort();
    test_random();
`ifdef FIR_COEFF_READBACK_EN
    test_readback();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
